matrix_loader: RTL
==================

Name: matrix_loader

Overview:
- Upstream stage of the convolution unit.
- Accepts a byte stream (dimensions, then elements row-major) over a valid/ready handshake.
- Packs the elements into the flat 200-bit, 8-bit-per-slot, row-major layout that the convolution unit consumes, together with the row and column counts.
- One instance loads the input matrix (stride 5); a second instance with KERNEL_MODE=1 loads the kernel (stride 3, 72 significant bits).

Parameters:
- MAX_DIM, 5, maximum rows/cols accepted and row stride of the packed output.
- ELEM_WIDTH, 8, bits per element and per input byte.
- KERNEL_MODE, 0, 0 = matrix layout (stride MAX_DIM, dims 1..MAX_DIM); 1 = kernel layout (stride 3, dims 1..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  ELEM_WIDTH  dimension or element byte, unsigned.
- in_ready  out  1  loader can accept a byte this cycle.
- mat_rows  out  3  loaded row count (feeds in_m / k_m).
- mat_cols  out  3  loaded column count (feeds in_n / k_n).
- matrix_out  out  MAX_DIM*MAX_DIM*ELEM_WIDTH  packed matrix; slot (r,c) at bits [(r*STRIDE+c)*ELEM_WIDTH +: ELEM_WIDTH].
- mat_valid  out  1  matrix_out / mat_rows / mat_cols hold a complete, checked load.
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  one-cycle pulse when a dimension byte is rejected.

Behaviour:
- Reset (reset==0 at a clock edge, any state): state=IDLE; in_ready=0, mat_rows=0, mat_cols=0, matrix_out=0, mat_valid=0, done=0, error=0; counters=0. Reset mid-load discards the partial load.
- Definitions: STRIDE = KERNEL_MODE ? 3 : MAX_DIM; DLIM = KERNEL_MODE ? 3 : MAX_DIM.
- A transfer occurs on a clock edge where in_valid && in_ready. in_ready is registered: 1 exactly in GET_ROWS, GET_COLS and GET_ELEM.
- IDLE: when start=1, go to GET_ROWS next cycle, clear matrix_out to 0, clear mat_valid.
- GET_ROWS: on a transfer, if 1 <= in_data <= DLIM, latch mat_rows = in_data[2:0] and go to GET_COLS. Otherwise pulse error next cycle, return to IDLE, set mat_rows=mat_cols=0.
- GET_COLS: same check and latch for mat_cols; on success go to GET_ELEM with r=0, c=0.
- GET_ELEM: each transfer writes in_data to slot (r,c), then:
  - c increments; when c == mat_cols-1, c wraps to 0 and r increments.
  - On the transfer where r == mat_rows-1 && c == mat_cols-1, go to DONE.
  - Slots outside rows x cols stay 0.
- DONE: done=1 for exactly this one cycle (the cycle after the last element transfer); mat_valid=1 from this cycle onward. Then hold outputs in DONE until start.
- start in DONE behaves as in IDLE and also drops mat_valid.
- start in GET_* states is ignored; there is no abort other than reset.
- in_valid with in_ready=0 is ignored; no byte is lost or queued.
- Gaps in in_valid are allowed anywhere; state and counters hold.
- Element count for a load: mat_rows*mat_cols, in 1..25 (kernel mode 1..9).
- Latency: minimum 2 + rows*cols + 1 cycles from the start cycle to done, with in_valid held high.
- No arithmetic on element values; bytes are stored verbatim.

Decomposition:
- Shared package matrix_pkg:
  - constants MAX_DIM=5, ELEM_WIDTH=8, KERNEL_DIM=3, MATRIX_BITS=200, KERNEL_BITS=72;
  - state enum {IDLE, GET_ROWS, GET_COLS, GET_ELEM, DONE}.
- The convolution unit reuses the same constants.
- No sub-module: the FSM, row/column counters and slot-write decode fit in one module.

Test Plan:
- Matrix mode: start; stream 3,3,1..9 continuously -> done 12 cycles after start; mat_rows=3, mat_cols=3; slot(1,2)=6 at bits [63:56]; slot(0,3)=0; mat_valid=1.
- Kernel mode: stream 2,2,1,2,3,4 -> slot(1,0)=3 at bits [31:24]; bits [199:72]=0; done single-cycle pulse.
- Invalid dims: rows byte 0 -> error pulse, state IDLE, in_ready=0. Rows byte 6 (or 4 in kernel mode) -> same; mat_valid stays 0.
- Handshake gaps: 5,5, then 25 bytes with in_valid toggling every cycle -> all 25 slots correct; done only after the 25th transfer.
- Reset mid-load: pull reset low after 4 elements -> next cycle all outputs 0, IDLE. A fresh 1x1 load of 0xAB -> matrix_out=0xAB, mat_rows=1, mat_cols=1.
- Start while busy: pulse start during GET_ELEM -> ignored; the load completes normally. start in DONE -> mat_valid drops next cycle, matrix_out cleared.

Source files
------------

// File: rtl/matrix_loader_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Constants and the loader state type shared by the matrix loaders and the
// convolution unit.
//   MAX_DIM      largest matrix row/column count and matrix row stride
//   ELEM_WIDTH   bits per element / per stream byte
//   KERNEL_DIM   largest kernel row/column count and kernel row stride
//   MATRIX_BITS  width of the packed matrix bus
//   KERNEL_BITS  significant bits of a packed kernel
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int unsigned MAX_DIM     = 5;
  localparam int unsigned ELEM_WIDTH  = 8;
  localparam int unsigned KERNEL_DIM  = 3;
  localparam int unsigned MATRIX_BITS = MAX_DIM * MAX_DIM * ELEM_WIDTH;
  localparam int unsigned KERNEL_BITS = KERNEL_DIM * KERNEL_DIM * ELEM_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    GET_ROWS,
    GET_COLS,
    GET_ELEM,
    DONE
  } load_state_e;

endpackage

// File: rtl/matrix_loader_if.sv
// -----------------------------------------------------------------------------
// matrix_loader_if
// Byte-stream input and packed-matrix output of one matrix loader.
//   start       request to begin a load (honoured in IDLE / DONE)
//   in_valid    in_data carries a byte
//   in_data     dimension or element byte
//   in_ready    loader accepts a byte this cycle
//   mat_rows    loaded row count
//   mat_cols    loaded column count
//   matrix_out  packed row-major matrix, ELEM_WIDTH bits per slot
//   mat_valid   outputs hold a complete load
//   done        one-cycle pulse when a load completes
//   error       one-cycle pulse when a dimension byte is rejected
// master: the stream producer / result consumer; slave: the loader.
// -----------------------------------------------------------------------------
interface matrix_loader_if #(
  parameter int unsigned MAX_DIM    = matrix_pkg::MAX_DIM,
  parameter int unsigned ELEM_WIDTH = matrix_pkg::ELEM_WIDTH
);

  logic                                  start;
  logic                                  in_valid;
  logic [ELEM_WIDTH-1:0]                 in_data;
  logic                                  in_ready;
  logic [2:0]                            mat_rows;
  logic [2:0]                            mat_cols;
  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrix_out;
  logic                                  mat_valid;
  logic                                  done;
  logic                                  error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mat_rows, mat_cols, matrix_out, mat_valid, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mat_rows, mat_cols, matrix_out, mat_valid, done, error
  );

endinterface

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
// Receives a byte stream (rows, cols, then rows*cols elements row-major) and
// packs the elements into the flat slot layout used by the convolution unit.
// With KERNEL_MODE=1 the row stride and dimension limit are KERNEL_DIM.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active low
//   bus    matrix_loader_if slave (stream in, packed matrix out)
// -----------------------------------------------------------------------------
module matrix_loader #(
  parameter int unsigned MAX_DIM     = matrix_pkg::MAX_DIM,
  parameter int unsigned ELEM_WIDTH  = matrix_pkg::ELEM_WIDTH,
  parameter bit          KERNEL_MODE = 1'b0
) (
  input logic            clk,
  input logic            reset,
  matrix_loader_if.slave bus
);

  import matrix_pkg::*;

  localparam int unsigned STRIDE   = KERNEL_MODE ? KERNEL_DIM : MAX_DIM;
  localparam int unsigned DLIM     = KERNEL_MODE ? KERNEL_DIM : MAX_DIM;
  localparam int unsigned NSLOT    = MAX_DIM * MAX_DIM;
  localparam int unsigned OUT_BITS = NSLOT * ELEM_WIDTH;

  localparam logic [ELEM_WIDTH-1:0] DIM_MIN = ELEM_WIDTH'(1);
  localparam logic [ELEM_WIDTH-1:0] DIM_MAX = ELEM_WIDTH'(DLIM);

  load_state_e         state_q, state_d;
  logic [2:0]          rows_q, rows_d;
  logic [2:0]          cols_q, cols_d;
  logic [2:0]          r_q, r_d;
  logic [2:0]          c_q, c_d;
  logic [OUT_BITS-1:0] matrix_q, matrix_d;
  logic                mat_valid_q, mat_valid_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                in_ready;
  logic                xfer;
  logic                dim_ok;
  int unsigned         slot_idx;

  // in_ready is a pure decode of the state register, so it changes only on
  // clock edges.
  assign in_ready = (state_q == GET_ROWS) || (state_q == GET_COLS) ||
                    (state_q == GET_ELEM);
  assign xfer     = bus.in_valid && in_ready;
  assign dim_ok   = (bus.in_data >= DIM_MIN) && (bus.in_data <= DIM_MAX);
  assign slot_idx = 32'(r_q) * STRIDE + 32'(c_q);

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    r_d         = r_q;
    c_d         = c_q;
    matrix_d    = matrix_q;
    mat_valid_d = mat_valid_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = GET_ROWS;
          matrix_d    = '0;
          mat_valid_d = 1'b0;
        end
      end

      GET_ROWS: begin
        if (xfer) begin
          if (dim_ok) begin
            rows_d  = bus.in_data[2:0];
            state_d = GET_COLS;
          end else begin
            rows_d  = '0;
            cols_d  = '0;
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end

      GET_COLS: begin
        if (xfer) begin
          if (dim_ok) begin
            cols_d  = bus.in_data[2:0];
            r_d     = '0;
            c_d     = '0;
            state_d = GET_ELEM;
          end else begin
            rows_d  = '0;
            cols_d  = '0;
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end

      GET_ELEM: begin
        if (xfer) begin
          // Constant-bounded slot scan keeps the write decode a plain mux
          // per slot rather than a variable part-select.
          for (int unsigned i = 0; i < NSLOT; i++) begin
            if (i == slot_idx) begin
              matrix_d[i*ELEM_WIDTH +: ELEM_WIDTH] = bus.in_data;
            end
          end
          if (c_q == cols_q - 3'd1) begin
            c_d = '0;
            if (r_q == rows_q - 3'd1) begin
              state_d     = DONE;
              done_d      = 1'b1;
              mat_valid_d = 1'b1;
            end else begin
              r_d = r_q + 3'd1;
            end
          end else begin
            c_d = c_q + 3'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      r_q         <= '0;
      c_q         <= '0;
      matrix_q    <= '0;
      mat_valid_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      r_q         <= r_d;
      c_q         <= c_d;
      matrix_q    <= matrix_d;
      mat_valid_q <= mat_valid_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.mat_rows   = rows_q;
  assign bus.mat_cols   = cols_q;
  assign bus.matrix_out = matrix_q;
  assign bus.mat_valid  = mat_valid_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule
